// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman target feeder: base encoding,
// score width and the feeder FSM state type.
package sw_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_G = 2'b01;
    localparam logic [1:0] BASE_T = 2'b10;
    localparam logic [1:0] BASE_C = 2'b11;

    localparam int SCORE_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_GAP    = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/sw_base_ram.sv
// Target-base buffer: one synchronous write port, one synchronous read port
// with one-cycle latency. Storage is never reset.
module sw_base_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [1:0]        i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [1:0]        o_rdata
);

    logic [1:0] r_mem [DEPTH];
    logic [1:0] r_rdata;

    // Read register returns 00 on cycles with no read so the downstream
    // data bus is quiet whenever nothing is being streamed.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= 2'b00;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sw_target_feeder.sv
// Buffers one target sequence, then streams it into the first PE of the array.
// Optional len_out port is enabled by defining SW_FEEDER_LEN_EN.
module sw_target_feeder
    import sw_pkg::*;
#(
    parameter int MAX_LEN    = 256,
    parameter int ADDR_W     = 8,
    parameter int GAP_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [1:0]      s_base,
    input  logic            s_last,
    input  logic            done_in,
    output logic [1:0]      data_out,
    output logic            en_out,
    output logic            busy,
`ifdef SW_FEEDER_LEN_EN
    output logic [ADDR_W:0] len_out,
`endif
    output logic            err_ovf
);

    localparam logic [ADDR_W:0] MAX_LEN_C = (ADDR_W+1)'(MAX_LEN);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    feeder_state_t     r_state;
    logic [ADDR_W:0]   r_wr_cnt;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W:0]   r_len;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_en_out;
    logic              r_err_ovf;

    logic              w_hs;
    logic              w_room;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic              w_re;
    logic              w_enter_stream;
    logic [ADDR_W:0]   w_len_next;

    assign s_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_hs    = s_valid && s_ready;
    assign w_room  = (r_wr_cnt < MAX_LEN_C);

    always_comb begin
        w_we           = 1'b0;
        w_waddr        = '0;
        w_len_next     = r_wr_cnt;
        w_enter_stream = 1'b0;
        if (r_state == ST_IDLE) begin
            w_we           = w_hs;
            w_len_next     = (ADDR_W+1)'(1);
            w_enter_stream = w_hs && s_last;
        end else if (r_state == ST_LOAD) begin
            // Past MAX_LEN the base is accepted but dropped; len saturates.
            w_we           = w_hs && w_room;
            w_waddr        = r_wr_cnt[ADDR_W-1:0];
            w_len_next     = w_room ? (r_wr_cnt + 1'b1) : r_wr_cnt;
            w_enter_stream = w_hs && s_last;
        end
    end

    // Reads are gated by rst so a reset mid-stream leaves data_out at 00.
    assign w_re = (r_state == ST_STREAM) && !rst;

    sw_base_ram #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (s_base),
        .i_re    (w_re),
        .i_raddr (r_rd_cnt[ADDR_W-1:0]),
        .o_rdata (data_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_len     <= '0;
            r_gap_cnt <= '0;
            r_en_out  <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_en_out <= (r_state == ST_STREAM);
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_wr_cnt <= (ADDR_W+1)'(1);
                        r_state  <= s_last ? ST_STREAM : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_hs) begin
                        if (w_room) begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                        end else begin
                            r_err_ovf <= 1'b1;
                        end
                        if (s_last) begin
                            r_state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                    if (r_rd_cnt == (r_len - 1'b1)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_wr_cnt <= '0;
                    if (done_in) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_enter_stream) begin
                r_len    <= w_len_next;
                r_rd_cnt <= '0;
            end
        end
    end

`ifdef SW_FEEDER_LEN_EN
    logic [ADDR_W:0] r_len_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_out <= '0;
        end else if (w_enter_stream) begin
            r_len_out <= w_len_next;
        end
    end

    assign len_out = r_len_out;
`endif

    assign en_out  = r_en_out;
    assign busy    = (r_state != ST_IDLE);
    assign err_ovf = r_err_ovf;

endmodule

// File: tb/tb_sw_target_feeder.sv
// Self-checking bench for sw_target_feeder (main instance MAX_LEN=16, plus a
// MAX_LEN=4 instance for overflow). Works with or without SW_FEEDER_LEN_EN.
module tb_sw_target_feeder;

    localparam int MAX_LEN = 16;
    localparam int ADDR_W  = 4;
    localparam int GAP     = 3;
    localparam int MAX4    = 4;
    localparam int ADDR4   = 2;
    localparam int GAP4    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [1:0] s_base = 2'b00;
    logic       s_last = 1'b0;
    logic       done_in = 1'b0;
    logic       s_ready, en_out, busy, err_ovf;
    logic [1:0] data_out;
    logic       v4 = 1'b0;
    logic       done4 = 1'b0;
    logic       ready4, en4, busy4, err4;
    logic [1:0] data4;
`ifdef SW_FEEDER_LEN_EN
    logic [ADDR_W:0] len_out;
    logic [ADDR4:0]  len4;
`endif

    sw_target_feeder #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_base(s_base),
        .s_last(s_last), .done_in(done_in), .data_out(data_out), .en_out(en_out),
        .busy(busy),
`ifdef SW_FEEDER_LEN_EN
        .len_out(len_out),
`endif
        .err_ovf(err_ovf));

    sw_target_feeder #(.MAX_LEN(MAX4), .ADDR_W(ADDR4), .GAP_CYCLES(GAP4)) u_dut4 (
        .clk(clk), .rst(rst), .s_valid(v4), .s_ready(ready4), .s_base(s_base),
        .s_last(s_last), .done_in(done4), .data_out(data4), .en_out(en4),
        .busy(busy4),
`ifdef SW_FEEDER_LEN_EN
        .len_out(len4),
`endif
        .err_ovf(err4));

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        int          n;
        logic [15:0] bases;
        int          exp_cnt;
        logic [15:0] exp_data;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] seq [32];
    logic [1:0] exp_q [$];
    bit         exp_err = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer seq[0..n-1] with random valid gaps and random done_in noise.
    task automatic load_main(input int n, input int vprob);
        int i = 0;
        int guard = 0;
        bit hs;
        while (i < n && guard < 1000) begin
            s_valid = ($urandom_range(0, 99) < vprob);
            s_base  = seq[i];
            s_last  = (i == n - 1);
            done_in = $urandom_range(0, 1);
            hs = s_valid && s_ready;
            tick();
            if (hs) i++;
            guard++;
        end
        if (guard >= 1000) check("load_timeout", i, n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        done_in = 1'b0;
        s_base  = 2'($urandom);
    endtask

    // Called in the cycle right after the s_last handshake.
    task automatic stream_check(input string tag);
        int cnt = exp_q.size();
        bit exp_en;
        check({tag, "_ready_low"}, int'(s_ready), 0);
        for (int k = 0; k < cnt + 3; k++) begin
            exp_en = (k >= 1) && (k <= cnt);
            check($sformatf("%s_en_k%0d", tag, k), int'(en_out), int'(exp_en));
            check($sformatf("%s_data_k%0d", tag, k), int'(data_out),
                  exp_en ? int'(exp_q[k-1]) : 0);
            done_in = (k < cnt) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        done_in = 1'b0;
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_err_ovf"}, int'(err_ovf), int'(exp_err));
`ifdef SW_FEEDER_LEN_EN
        check({tag, "_len_out"}, int'(len_out), cnt);
`endif
    endtask

    task automatic drain_gap(input string tag, input int hold);
        int k = 0;
        int stuck = 0;
        for (int h = 0; h < hold; h++) begin
            if (s_ready) stuck++;
            tick();
        end
        check({tag, "_drain_hold_ready"}, stuck, 0);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        while (!s_ready && k < 40) begin
            tick();
            k++;
        end
        // k extra edges after the one that sampled done_in => k+1 cycles.
        check({tag, "_gap_latency"}, k + 1, GAP + 1);
        check({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    task automatic set_exp(input int n);
        exp_q.delete();
        for (int i = 0; i < n && i < MAX_LEN; i++) exp_q.push_back(seq[i]);
        if (n > MAX_LEN) exp_err = 1'b1;
    endtask

    initial begin
        vec_t tbl [4];
        int   n, vp, i, k, guard;
        bit   hs;

        // A,G,T,C / single T / CCAAGGTT / G,A,C packed two bits per base, LSB first.
        tbl[0] = '{n: 4, bases: 16'h00E4, exp_cnt: 4, exp_data: 16'h00E4};
        tbl[1] = '{n: 1, bases: 16'h0002, exp_cnt: 1, exp_data: 16'h0002};
        tbl[2] = '{n: 8, bases: 16'hA50F, exp_cnt: 8, exp_data: 16'hA50F};
        tbl[3] = '{n: 3, bases: 16'h0031, exp_cnt: 3, exp_data: 16'h0031};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_en_out", int'(en_out), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err_ovf", int'(err_ovf), 0);
`ifdef SW_FEEDER_LEN_EN
        check("rst_len_out", int'(len_out), 0);
`endif

        // Overflow on the MAX_LEN=4 instance: six bases, only four stream.
        for (int j = 0; j < 6; j++) seq[j] = 2'($urandom);
        i = 0;
        guard = 0;
        while (i < 6 && guard < 50) begin
            v4 = 1'b1;
            s_base = seq[i];
            s_last = (i == 5);
            check($sformatf("ovf_ready_b%0d", i), int'(ready4), 1);
            hs = v4 && ready4;
            tick();
            if (hs) i++;
            guard++;
        end
        v4 = 1'b0;
        s_last = 1'b0;
        for (int j = 0; j < 7; j++) begin
            check($sformatf("ovf_en_k%0d", j), int'(en4), int'(j >= 1 && j <= 4));
            check($sformatf("ovf_data_k%0d", j), int'(data4),
                  (j >= 1 && j <= 4) ? int'(seq[j-1]) : 0);
            tick();
        end
        check("ovf_err", int'(err4), 1);
`ifdef SW_FEEDER_LEN_EN
        check("ovf_len_out", int'(len4), 4);
`endif
        done4 = 1'b1;
        tick();
        done4 = 1'b0;
        k = 0;
        while (!ready4 && k < 40) begin
            tick();
            k++;
        end
        check("ovf_gap_latency", k + 1, GAP4 + 1);

        // Directed table on the main instance.
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < tbl[t].n; j++) seq[j] = tbl[t].bases[2*j +: 2];
            exp_q.delete();
            for (int j = 0; j < tbl[t].exp_cnt; j++) exp_q.push_back(tbl[t].exp_data[2*j +: 2]);
            load_main(tbl[t].n, 100);
            stream_check($sformatf("tbl%0d", t));
            drain_gap($sformatf("tbl%0d", t), (t == 0) ? 10 : 2);
        end

        // Random sequences with gappy valid against the reference model.
        for (int r = 0; r < 15; r++) begin
            n  = $urandom_range(1, 12);
            vp = $urandom_range(30, 100);
            for (int j = 0; j < n; j++) seq[j] = 2'($urandom);
            set_exp(n);
            load_main(n, vp);
            stream_check($sformatf("rnd%0d", r));
            drain_gap($sformatf("rnd%0d", r), $urandom_range(0, 6));
        end

        // Overflow on the main instance: 18 bases with MAX_LEN=16.
        n = 18;
        for (int j = 0; j < n; j++) seq[j] = 2'($urandom);
        set_exp(n);
        load_main(n, 70);
        stream_check("ovf16");
        drain_gap("ovf16", 3);

        // Reset during the second en_out cycle of an 8-base stream.
        for (int j = 0; j < 8; j++) seq[j] = 2'($urandom);
        load_main(8, 100);
        tick();
        check("rstmid_en1", int'(en_out), 1);
        check("rstmid_d1", int'(data_out), int'(seq[0]));
        tick();
        check("rstmid_en2", int'(en_out), 1);
        check("rstmid_d2", int'(data_out), int'(seq[1]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        check("rstmid_en_after", int'(en_out), 0);
        check("rstmid_data_after", int'(data_out), 0);
        check("rstmid_busy_after", int'(busy), 0);
        check("rstmid_err_after", int'(err_ovf), 0);
`ifdef SW_FEEDER_LEN_EN
        check("rstmid_len_after", int'(len_out), 0);
`endif
        k = 0;
        for (int j = 0; j < 6; j++) begin
            if (en_out || data_out != 2'b00) k++;
            tick();
        end
        check("rstmid_no_more_bases", k, 0);
        check("rstmid_ready", int'(s_ready), 1);

        for (int j = 0; j < 8; j++) seq[j] = 2'($urandom);
        set_exp(8);
        load_main(8, 60);
        stream_check("post_rst");
        drain_gap("post_rst", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
